// File: rtl/vid_rd_frame_addr_gen.sv
// Read-side frame address generator: latches the frame base on VS and issues burst read
// commands line by line on downstream request. Optional frame counter: RD_FRAME_CNT_EN.
module vid_rd_frame_addr_gen #(
    parameter int                  ADDR_BITS       = 25,
    parameter int                  BURSTS_PER_LINE = 10,
    parameter int                  LINES           = 720,
    parameter logic [ADDR_BITS-1:0] BURST_STRIDE   = 25'h40,
    parameter logic [ADDR_BITS-1:0] LINE_STRIDE    = 25'h800
) (
    input  logic                 read_clk,
    input  logic                 read_rst,
    input  logic                 enable,
    input  logic                 read_vs,
    input  logic [ADDR_BITS-1:0] read_base,
    input  logic                 line_req,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [ADDR_BITS-1:0] cmd_addr,
    output logic                 cmd_last,
    output logic                 frame_done,
    output logic                 frame_abort,
    output logic                 line_req_ovf,
`ifdef RD_FRAME_CNT_EN
    output logic [15:0]          frame_cnt,
`endif
    output logic                 busy
);
    localparam int BW = $clog2(BURSTS_PER_LINE + 1);
    localparam int LW = $clog2(LINES + 1);
    localparam logic [BW-1:0] LAST_BURST = BW'(BURSTS_PER_LINE - 1);
    localparam logic [LW-1:0] LAST_LINE  = LW'(LINES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_LINE, S_ISSUE, S_DONE} state_t;

    state_t               r_state;
    logic                 r_vs_d, r_cmd_valid, r_cmd_last, r_frame_done, r_frame_abort;
    logic                 r_ovf, r_busy, r_restart, r_rs_en;
    logic [ADDR_BITS-1:0] r_cmd_addr, r_line_addr, r_rs_base;
    logic [BW-1:0]        r_burst_idx;
    logic [LW-1:0]        r_line_idx;
    logic [1:0]           r_pending;

    logic                 w_edge, w_accept, w_leave_wait, w_final, w_abort, w_start, w_start_en;
    logic [ADDR_BITS-1:0] w_start_base;

    // A frame start can come from IDLE, from DONE (VS seen on the final accept), or from an abort.
    always_comb begin
        w_edge       = read_vs & ~r_vs_d;
        w_accept     = r_cmd_valid & cmd_ready;
        w_leave_wait = (r_state == S_WAIT_LINE) && (r_pending != 2'd0 || line_req);
        w_final      = w_accept && r_cmd_last && (r_line_idx == LAST_LINE);
        w_abort      = 1'b0;
        w_start      = 1'b0;
        w_start_en   = enable;
        w_start_base = read_base;
        case (r_state)
            S_IDLE: w_start = w_edge & enable;
            S_DONE: begin
                if (r_restart) begin
                    w_start_en   = r_rs_en;
                    w_start_base = r_rs_base;
                end
                w_start = r_restart ? r_rs_en : (w_edge & enable);
            end
            default: begin
                if (w_edge && !w_final && (!r_cmd_valid || w_accept)) begin
                    w_abort = 1'b1;
                end else if (r_restart && w_accept) begin
                    w_abort = 1'b1;
                    if (!w_edge) begin
                        w_start_en   = r_rs_en;
                        w_start_base = r_rs_base;
                    end
                end
                w_start = w_abort & w_start_en;
            end
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            r_state       <= S_IDLE;
            r_vs_d        <= 1'b0;
            r_cmd_valid   <= 1'b0;
            r_cmd_last    <= 1'b0;
            r_cmd_addr    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;
            r_ovf         <= 1'b0;
            r_busy        <= 1'b0;
            r_restart     <= 1'b0;
            r_rs_en       <= 1'b0;
            r_rs_base     <= '0;
            r_line_addr   <= '0;
            r_burst_idx   <= '0;
            r_line_idx    <= '0;
            r_pending     <= '0;
        end else begin
            r_vs_d        <= read_vs;
            r_frame_done  <= 1'b0;
            r_frame_abort <= 1'b0;

            if (w_start || w_abort) begin
                r_pending <= '0;
            end else if (line_req && !w_leave_wait) begin
                if (r_pending == 2'd3) r_ovf <= 1'b1;
                else                   r_pending <= r_pending + 2'd1;
            end else if (!line_req && w_leave_wait) begin
                r_pending <= r_pending - 2'd1;
            end

            // VS while a command is held (or on the final accept) is remembered, not acted on yet
            if (w_abort || r_state == S_DONE) r_restart <= 1'b0;
            if (w_edge && !w_abort && (r_state == S_WAIT_LINE || r_state == S_ISSUE)) begin
                r_restart <= 1'b1;
                r_rs_en   <= enable;
                r_rs_base <= read_base;
            end

            if (w_start) begin
                r_state       <= S_WAIT_LINE;
                r_line_addr   <= w_start_base;
                r_burst_idx   <= '0;
                r_line_idx    <= '0;
                r_busy        <= 1'b1;
                r_cmd_valid   <= 1'b0;
                r_cmd_last    <= 1'b0;
                r_frame_abort <= w_abort;
            end else if (w_abort) begin
                r_state       <= S_IDLE;
                r_busy        <= 1'b0;
                r_cmd_valid   <= 1'b0;
                r_cmd_last    <= 1'b0;
                r_frame_abort <= 1'b1;
            end else begin
                case (r_state)
                    S_WAIT_LINE: if (w_leave_wait) begin
                        r_state     <= S_ISSUE;
                        r_cmd_valid <= 1'b1;
                        r_cmd_addr  <= r_line_addr;
                        r_cmd_last  <= (LAST_BURST == '0);
                    end
                    S_ISSUE: if (w_accept) begin
                        if (r_cmd_last) begin
                            r_cmd_valid <= 1'b0;
                            r_cmd_last  <= 1'b0;
                            r_line_addr <= r_line_addr + LINE_STRIDE;
                            r_line_idx  <= r_line_idx + LW'(1);
                            r_burst_idx <= '0;
                            if (r_line_idx == LAST_LINE) begin
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                                r_busy       <= 1'b0;
                            end else begin
                                r_state <= S_WAIT_LINE;
                            end
                        end else begin
                            r_cmd_addr  <= r_cmd_addr + BURST_STRIDE;
                            r_burst_idx <= r_burst_idx + BW'(1);
                            r_cmd_last  <= (r_burst_idx + BW'(1) == LAST_BURST);
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: ;
                endcase
            end
        end
    end

`ifdef RD_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;
    always_ff @(posedge read_clk) begin
        if (read_rst)          r_frame_cnt <= '0;
        else if (r_frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
    assign frame_cnt = r_frame_cnt;
`endif

    assign cmd_valid    = r_cmd_valid;
    assign cmd_addr     = r_cmd_addr;
    assign cmd_last     = r_cmd_last;
    assign frame_done   = r_frame_done;
    assign frame_abort  = r_frame_abort;
    assign line_req_ovf = r_ovf;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vid_rd_frame_addr_gen.sv
// Directed bench for vid_rd_frame_addr_gen (2 bursts/line, 3 lines, strides 0x40/0x100).
module tb_vid_rd_frame_addr_gen;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b1, read_vs = 1'b0, line_req = 1'b0, cmd_ready = 1'b1;
    logic [24:0] read_base = '0, cmd_addr;
    logic        cmd_valid, cmd_last, frame_done, frame_abort, line_req_ovf, busy;
`ifdef RD_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    vid_rd_frame_addr_gen #(
        .ADDR_BITS(25), .BURSTS_PER_LINE(2), .LINES(3),
        .BURST_STRIDE(25'h40), .LINE_STRIDE(25'h100)
    ) dut (
        .read_clk(clk), .read_rst(rst), .enable(enable), .read_vs(read_vs),
        .read_base(read_base), .line_req(line_req), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_last(cmd_last),
        .frame_done(frame_done), .frame_abort(frame_abort), .line_req_ovf(line_req_ovf),
`ifdef RD_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic vs_start(input logic [24:0] base);
        read_base = base;
        read_vs   = 1'b1;
        tick();
        read_vs   = 1'b0;
        chk("start_busy", {31'd0, busy}, 32'd1);
    endtask

    // one line with cmd_ready held high: request, two accepted bursts, gap
    task automatic issue_line(input logic [24:0] a0, input logic [24:0] a1);
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        chk("l_valid0", {31'd0, cmd_valid}, 32'd1);
        chk("l_addr0", {7'd0, cmd_addr}, {7'd0, a0});
        chk("l_last0", {31'd0, cmd_last}, 32'd0);
        tick();
        chk("l_addr1", {7'd0, cmd_addr}, {7'd0, a1});
        chk("l_last1", {31'd0, cmd_last}, 32'd1);
        tick();
        chk("l_gap", {31'd0, cmd_valid}, 32'd0);
    endtask

    task automatic chk_done();
        chk("done_pulse", {31'd0, frame_done}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("done_clear", {31'd0, frame_done}, 32'd0);
    endtask

    initial begin
        bit seen;
        tick(); tick();
        chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, line_req_ovf}, 32'd0);
        chk("rst_addr", {7'd0, cmd_addr}, 32'd0);
        rst = 1'b0;
        tick();

        // nominal frame
        vs_start(25'h100000);
        chk("wait_novalid", {31'd0, cmd_valid}, 32'd0);
        issue_line(25'h100000, 25'h100040);
        issue_line(25'h100100, 25'h100140);
        issue_line(25'h100200, 25'h100240);
        chk_done();

        // backpressure on second burst of line 0
        vs_start(25'h100000);
        line_req = 1'b1;
        tick();
        line_req = 1'b0;
        chk("bp_addr0", {7'd0, cmd_addr}, 32'h100000);
        tick();
        cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", {31'd0, cmd_valid}, 32'd1);
            chk("bp_hold_addr", {7'd0, cmd_addr}, 32'h100040);
        end
        cmd_ready = 1'b1;
        tick();
        chk("bp_release", {31'd0, cmd_valid}, 32'd0);
        issue_line(25'h100100, 25'h100140);
        issue_line(25'h100200, 25'h100240);
        chk_done();
`ifdef RD_FRAME_CNT_EN
        chk("frame_cnt2", {16'd0, frame_cnt}, 32'd2);
`endif

        // address wrap
        vs_start(25'h1FFFF80);
        issue_line(25'h1FFFF80, 25'h1FFFFC0);
        issue_line(25'h0000080, 25'h00000C0);
        issue_line(25'h0000180, 25'h00001C0);
        chk_done();

        // restart while a command is held
        vs_start(25'h100000);
        issue_line(25'h100000, 25'h100040);
        line_req  = 1'b1;
        cmd_ready = 1'b0;
        tick();
        line_req  = 1'b0;
        chk("rs_held_addr", {7'd0, cmd_addr}, 32'h100100);
        read_vs   = 1'b1;
        read_base = 25'h200000;
        tick();
        read_base = 25'h0;
        chk("rs_still_valid", {31'd0, cmd_valid}, 32'd1);
        chk("rs_no_abort_yet", {31'd0, frame_abort}, 32'd0);
        chk("rs_addr_kept", {7'd0, cmd_addr}, 32'h100100);
        cmd_ready = 1'b1;
        tick();
        read_vs   = 1'b0;
        chk("rs_abort", {31'd0, frame_abort}, 32'd1);
        chk("rs_valid_drop", {31'd0, cmd_valid}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("rs_abort_pulse", {31'd0, frame_abort}, 32'd0);
        issue_line(25'h200000, 25'h200040);
        issue_line(25'h200100, 25'h200140);
        issue_line(25'h200200, 25'h200240);
        chk_done();

        // line request overflow while stalled
        vs_start(25'h300000);
        cmd_ready = 1'b0;
        line_req  = 1'b1;
        tick();
        line_req  = 1'b0;
        chk("ovf_addr", {7'd0, cmd_addr}, 32'h300000);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) chk("ovf_before", {31'd0, line_req_ovf}, 32'd0);
            line_req = 1'b1;
            tick();
            line_req = 1'b0;
            tick();
        end
        chk("ovf_set", {31'd0, line_req_ovf}, 32'd1);
        cmd_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (frame_done) seen = 1'b1;
        end
        chk("ovf_frame_done", {31'd0, seen}, 32'd1);
        chk("ovf_sticky", {31'd0, line_req_ovf}, 32'd1);
`ifdef RD_FRAME_CNT_EN
        tick();
        chk("frame_cnt5", {16'd0, frame_cnt}, 32'd5);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("ovf_cleared", {31'd0, line_req_ovf}, 32'd0);

        // VS with enable low is ignored
        enable    = 1'b0;
        read_base = 25'h400000;
        read_vs   = 1'b1;
        tick();
        read_vs   = 1'b0;
        line_req  = 1'b1;
        tick();
        line_req  = 1'b0;
        tick();
        chk("dis_busy", {31'd0, busy}, 32'd0);
        chk("dis_valid", {31'd0, cmd_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
